frog_game_ctrl: RTL and testbench
=================================

// Module: frog_game_ctrl
// PURPOSE
//  Game sequencer for the frog grid game. Sits above frog_display and the car movers.
//  Tracks lives and level, and issues reset_frog. Generates the car-movement tick,
//  whose period shortens as the level rises. Drives status outputs for the display layer.
// PARAMETERS
//  START_LIVES    3           lives loaded on game start (1..3)
//  MAX_LEVEL      7           last level; crossing at MAX_LEVEL -> WIN (1..7)
//  TICK_BASE      12_500_000  car_tick period in clk cycles at level 0
//  TICK_STEP      1_250_000   period reduction per level
//  TICK_MIN       2_500_000   period floor
//  PAUSE_CYCLES   25_000_000  length of HIT and LEVEL_UP pauses
// PORTS
//  clk                 in   1  system clock, single domain
//  rst_n               in   1  reset, asynchronous assert, active-low
//  start_btn           in   1  debounced start/restart button, level
//  collision_detected  in   1  from frog_display
//  frog_at_top         in   1  from frog_display, level while frog_row==0
//  reset_frog          out  1  hold frog at spawn (center column, bottom row)
//  car_tick            out  1  1-cycle pulse, advance all cars one column
//  level               out  3  current level, 0-based
//  lives               out  2  remaining lives
//  state               out  3  FSM state encoding (package)
//  game_over           out  1  high in LOSE or WIN
//  flash               out  1  high during HIT/LEVEL_UP pauses (display blink)
// BEHAVIOUR
//  Reset values (async, rst_n=0):
//   - state=IDLE, level=0, lives=START_LIVES, reset_frog=1, car_tick=0,
//     game_over=0, flash=0, timers=0.
//  start_btn: rising edge is detected internally (registered previous value).
//   - A held button generates only one start.
//  FSM states and transitions:
//   - IDLE: reset_frog=1, no ticks. On start edge: lives=START_LIVES, level=0 -> PLAY.
//   - PLAY: reset_frog=0, car_tick active.
//       collision_detected -> lives-1.
//         If lives was 1: -> LOSE. Otherwise: -> HIT.
//       Else frog_at_top and level==MAX_LEVEL -> WIN.
//       Else frog_at_top -> level+1, -> LEVEL_UP.
//       Collision and top in the same cycle: collision wins.
//   - HIT and LEVEL_UP: reset_frog=1, flash=1, car_tick=0.
//       pause counter runs 0..PAUSE_CYCLES-1, then -> PLAY.
//       Inputs are ignored during the pause.
//   - LOSE and WIN: game_over=1, reset_frog=1, car_tick=0. On start edge -> IDLE.
//  Output timing: state-decoded outputs are registered and change on the cycle
//   after the transition edge. Any event-to-reset_frog latency is 1 clk.
//  Tick generator:
//   - Period P = max(TICK_BASE - level*TICK_STEP, TICK_MIN).
//   - Counter clears on PLAY entry; first pulse comes P cycles after entry.
//   - Counter compares >= P-1, so a level change mid-count never overshoots.
//   - Width is $clog2(TICK_BASE).
//  Saturation: lives never underflows; level never exceeds MAX_LEVEL.
//  rst_n asserted mid-game returns all outputs to reset values immediately.
// STRUCTURE
//  Package frog_pkg:
//   - state encoding localparams (IDLE=0, PLAY=1, HIT=2, LEVEL_UP=3, LOSE=4, WIN=5)
//   - GRID_COLS=20, GRID_ROWS=15
//  Sub-module frog_tick_gen:
//   - inputs: clk, rst_n, enable, clear, period
//   - output: 1-cycle pulse
//  Top module contains the FSM, the pause counter and the lives/level registers.
// TESTING
//  (TICK_BASE=10, TICK_STEP=2, TICK_MIN=4, PAUSE_CYCLES=5, START_LIVES=3, MAX_LEVEL=2)
//  1. Reset, then start edge:
//     -> state=PLAY, lives=3, level=0, reset_frog=0 next cycle;
//        car_tick every 10 cycles.
//  2. Collision pulse in PLAY:
//     -> lives=2, state=HIT, reset_frog=1, flash=1 for 5 cycles, no car_tick;
//        then PLAY.
//  3. frog_at_top twice:
//     -> level 1 then 2, with tick period 8 then 6.
//     Third frog_at_top at level 2 -> WIN, game_over=1.
//  4. Three collisions:
//     -> lives 2, 1, then LOSE with lives=0.
//     Start held high -> only one transition to IDLE.
//  5. collision_detected and frog_at_top in the same cycle:
//     -> HIT, level unchanged, lives decremented.
//  6. rst_n pulsed low mid-HIT:
//     -> outputs return to reset values in the same cycle;
//        no car_tick until the next start.

Source files
------------

// File: rtl/frog_game_ctrl_pkg.sv
// frog_pkg: shared state encoding, grid size and car-tick period helper
package frog_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PLAY     = 3'd1,
        HIT      = 3'd2,
        LEVEL_UP = 3'd3,
        LOSE     = 3'd4,
        WIN      = 3'd5
    } state_t;

    localparam int GRID_COLS = 20;
    localparam int GRID_ROWS = 15;

    function automatic int tick_period(input logic [2:0] lvl, input int base, input int step, input int floor_p);
        int p;
        p = base - int'(lvl) * step;
        return (p < floor_p) ? floor_p : p;
    endfunction

endpackage

// File: rtl/frog_game_ctrl_if.sv
// frog_game_ctrl_if: player/display inputs and status outputs of the game sequencer
interface frog_game_ctrl_if;
    import frog_pkg::*;

    logic       start_btn;
    logic       collision_detected;
    logic       frog_at_top;
    logic       reset_frog;
    logic       car_tick;
    logic [2:0] level;
    logic [1:0] lives;
    state_t     state;
    logic       game_over;
    logic       flash;

    modport master (
        output start_btn, collision_detected, frog_at_top,
        input  reset_frog, car_tick, level, lives, state, game_over, flash
    );

    modport slave (
        input  start_btn, collision_detected, frog_at_top,
        output reset_frog, car_tick, level, lives, state, game_over, flash
    );

endinterface

// File: rtl/frog_game_ctrl_tick_gen.sv
// frog_tick_gen: free-running divider emitting a 1-cycle pulse every period cycles
module frog_tick_gen #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         clear,
    input  logic [W:0]   period,
    output logic         pulse
);

    logic [W-1:0] cnt;

    // >= compare lets a shortened period take effect without wrapping past it
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt   <= '0;
            pulse <= 1'b0;
        end else if (clear) begin
            cnt   <= '0;
            pulse <= 1'b0;
        end else if (enable && {1'b0, cnt} >= period - 1'b1) begin
            cnt   <= '0;
            pulse <= 1'b1;
        end else begin
            cnt   <= enable ? cnt + 1'b1 : cnt;
            pulse <= 1'b0;
        end

endmodule

// File: rtl/frog_game_ctrl.sv
// frog_game_ctrl: game sequencer tracking lives/level, frog respawn and car tick rate
module frog_game_ctrl
    import frog_pkg::*;
#(
    parameter int START_LIVES  = 3,
    parameter int MAX_LEVEL    = 7,
    parameter int TICK_BASE    = 12_500_000,
    parameter int TICK_STEP    = 1_250_000,
    parameter int TICK_MIN     = 2_500_000,
    parameter int PAUSE_CYCLES = 25_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    frog_game_ctrl_if.slave io
);

    localparam int TW = $clog2(TICK_BASE);
    localparam int PW = $clog2(PAUSE_CYCLES + 1);

    logic          start_q;
    logic          start_edge;
    logic [PW-1:0] pause_cnt;
    logic [TW:0]   period;
    logic          tick;

    assign start_edge = io.start_btn & ~start_q;
    assign period     = (TW+1)'(tick_period(io.level, TICK_BASE, TICK_STEP, TICK_MIN));

    // counter is held clear outside PLAY so each PLAY entry restarts a full period
    frog_tick_gen #(.W(TW)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (io.state == PLAY),
        .clear  (io.state != PLAY),
        .period (period),
        .pulse  (tick)
    );

    assign io.car_tick = tick & (io.state == PLAY);

    // game FSM; outputs are registered alongside the state they decode
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            io.state      <= IDLE;
            io.level      <= '0;
            io.lives      <= 2'(START_LIVES);
            io.reset_frog <= 1'b1;
            io.game_over  <= 1'b0;
            io.flash      <= 1'b0;
            start_q       <= 1'b0;
            pause_cnt     <= '0;
        end else begin
            start_q <= io.start_btn;
            case (io.state)
                IDLE:
                    if (start_edge) begin
                        io.lives      <= 2'(START_LIVES);
                        io.level      <= '0;
                        io.state      <= PLAY;
                        io.reset_frog <= 1'b0;
                    end
                PLAY:
                    if (io.collision_detected) begin
                        io.lives      <= (io.lives != 2'd0) ? io.lives - 1'b1 : 2'd0;
                        io.state      <= (io.lives <= 2'd1) ? LOSE : HIT;
                        io.flash      <= io.lives > 2'd1;
                        io.game_over  <= io.lives <= 2'd1;
                        io.reset_frog <= 1'b1;
                        pause_cnt     <= '0;
                    end else if (io.frog_at_top) begin
                        io.reset_frog <= 1'b1;
                        if (io.level >= 3'(MAX_LEVEL)) begin
                            io.state     <= WIN;
                            io.game_over <= 1'b1;
                        end else begin
                            io.level  <= io.level + 1'b1;
                            io.state  <= LEVEL_UP;
                            io.flash  <= 1'b1;
                            pause_cnt <= '0;
                        end
                    end
                HIT, LEVEL_UP:
                    if (pause_cnt == PW'(PAUSE_CYCLES - 1)) begin
                        io.state      <= PLAY;
                        io.reset_frog <= 1'b0;
                        io.flash      <= 1'b0;
                    end else
                        pause_cnt <= pause_cnt + 1'b1;
                LOSE, WIN:
                    if (start_edge) begin
                        io.state     <= IDLE;
                        io.game_over <= 1'b0;
                    end
                default:
                    io.state <= IDLE;
            endcase
        end

endmodule

// File: tb/tb_frog_game_ctrl.sv
// tb_frog_game_ctrl: scenario bench for the game sequencer with a car-tick scoreboard
module tb_frog_game_ctrl;
    import frog_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;
    int   exp_q[$];

    always #5 clk = ~clk;

    frog_game_ctrl_if io();

    frog_game_ctrl #(
        .START_LIVES  (3),
        .MAX_LEVEL    (2),
        .TICK_BASE    (10),
        .TICK_STEP    (2),
        .TICK_MIN     (4),
        .PAUSE_CYCLES (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic s, input logic c, input logic t);
        io.start_btn = s;
        io.collision_detected = c;
        io.frog_at_top = t;
        step(1);
        io.start_btn = 1'b0;
        io.collision_detected = 1'b0;
        io.frog_at_top = 1'b0;
    endtask

    task automatic measure_tick(input string name);
        int n;
        int want;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!io.car_tick && n < 40);
        want = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        total++; if (n !== want) $display("FAIL %s tick_interval got=%0d want=%0d", name, n, want); else passed++;
    endtask

    task automatic wait_play(input string name);
        int n;
        int fl;
        int tk;
        n = 0; fl = 0; tk = 0;
        while (io.state != PLAY && n < 20) begin
            if (io.flash) fl++;
            if (io.car_tick) tk++;
            step(1);
            n++;
        end
        total++; if (n !== 5) $display("FAIL %s pause_len got=%0d want=5", name, n); else passed++;
        total++; if (fl !== 5) $display("FAIL %s flash_cycles got=%0d want=5", name, fl); else passed++;
        total++; if (tk !== 0) $display("FAIL %s pause_ticks got=%0d want=0", name, tk); else passed++;
    endtask

    task automatic count_idle_ticks(input string name, input int cycles, input state_t st);
        int tk;
        tk = 0;
        repeat (cycles) begin
            step(1);
            if (io.car_tick) tk++;
        end
        total++; if (tk !== 0) $display("FAIL %s ticks got=%0d want=0", name, tk); else passed++;
        total++; if (io.state !== st) $display("FAIL %s state got=%0d want=%0d", name, io.state, st); else passed++;
    endtask

    task automatic check_reset_values(input string name);
        total++; if (io.state !== IDLE) $display("FAIL %s state got=%0d want=%0d", name, io.state, IDLE); else passed++;
        total++; if (io.level !== 3'd0) $display("FAIL %s level got=%0d want=0", name, io.level); else passed++;
        total++; if (io.lives !== 2'd3) $display("FAIL %s lives got=%0d want=3", name, io.lives); else passed++;
        total++; if (io.reset_frog !== 1'b1) $display("FAIL %s reset_frog got=%b want=1", name, io.reset_frog); else passed++;
        total++; if (io.car_tick !== 1'b0) $display("FAIL %s car_tick got=%b want=0", name, io.car_tick); else passed++;
        total++; if (io.game_over !== 1'b0) $display("FAIL %s game_over got=%b want=0", name, io.game_over); else passed++;
        total++; if (io.flash !== 1'b0) $display("FAIL %s flash got=%b want=0", name, io.flash); else passed++;
    endtask

    task automatic test_reset();
        io.start_btn = 1'b0;
        io.collision_detected = 1'b0;
        io.frog_at_top = 1'b0;
        step(2);
        check_reset_values("reset");
        rst_n = 1'b1;
        count_idle_ticks("idle", 15, IDLE);
    endtask

    task automatic test_start();
        drive(1'b1, 1'b0, 1'b0);
        total++; if (io.state !== PLAY) $display("FAIL start state got=%0d want=%0d", io.state, PLAY); else passed++;
        total++; if (io.lives !== 2'd3) $display("FAIL start lives got=%0d want=3", io.lives); else passed++;
        total++; if (io.level !== 3'd0) $display("FAIL start level got=%0d want=0", io.level); else passed++;
        total++; if (io.reset_frog !== 1'b0) $display("FAIL start reset_frog got=%b want=0", io.reset_frog); else passed++;
        exp_q.push_back(10);
        exp_q.push_back(10);
        measure_tick("start_first");
        measure_tick("start_second");
    endtask

    task automatic test_hit();
        drive(1'b0, 1'b1, 1'b0);
        total++; if (io.state !== HIT) $display("FAIL hit state got=%0d want=%0d", io.state, HIT); else passed++;
        total++; if (io.lives !== 2'd2) $display("FAIL hit lives got=%0d want=2", io.lives); else passed++;
        total++; if (io.reset_frog !== 1'b1) $display("FAIL hit reset_frog got=%b want=1", io.reset_frog); else passed++;
        total++; if (io.car_tick !== 1'b0) $display("FAIL hit car_tick got=%b want=0", io.car_tick); else passed++;
        wait_play("hit");
        total++; if (io.reset_frog !== 1'b0) $display("FAIL hit_resume reset_frog got=%b want=0", io.reset_frog); else passed++;
        total++; if (io.flash !== 1'b0) $display("FAIL hit_resume flash got=%b want=0", io.flash); else passed++;
        exp_q.push_back(10);
        measure_tick("hit_resume");
    endtask

    task automatic test_levels();
        drive(1'b0, 1'b0, 1'b1);
        total++; if (io.state !== LEVEL_UP) $display("FAIL lvl1 state got=%0d want=%0d", io.state, LEVEL_UP); else passed++;
        total++; if (io.level !== 3'd1) $display("FAIL lvl1 level got=%0d want=1", io.level); else passed++;
        wait_play("lvl1");
        exp_q.push_back(8);
        exp_q.push_back(8);
        measure_tick("lvl1_first");
        measure_tick("lvl1_second");
        drive(1'b0, 1'b0, 1'b1);
        total++; if (io.level !== 3'd2) $display("FAIL lvl2 level got=%0d want=2", io.level); else passed++;
        wait_play("lvl2");
        exp_q.push_back(6);
        measure_tick("lvl2");
        drive(1'b0, 1'b0, 1'b1);
        total++; if (io.state !== WIN) $display("FAIL win state got=%0d want=%0d", io.state, WIN); else passed++;
        total++; if (io.game_over !== 1'b1) $display("FAIL win game_over got=%b want=1", io.game_over); else passed++;
        total++; if (io.level !== 3'd2) $display("FAIL win level got=%0d want=2", io.level); else passed++;
        total++; if (io.reset_frog !== 1'b1) $display("FAIL win reset_frog got=%b want=1", io.reset_frog); else passed++;
        total++; if (io.flash !== 1'b0) $display("FAIL win flash got=%b want=0", io.flash); else passed++;
        count_idle_ticks("win_hold", 15, WIN);
    endtask

    task automatic test_lose();
        drive(1'b1, 1'b0, 1'b0);
        total++; if (io.state !== IDLE) $display("FAIL restart state got=%0d want=%0d", io.state, IDLE); else passed++;
        total++; if (io.game_over !== 1'b0) $display("FAIL restart game_over got=%b want=0", io.game_over); else passed++;
        step(1);
        drive(1'b1, 1'b0, 1'b0);
        total++; if (io.lives !== 2'd3) $display("FAIL replay lives got=%0d want=3", io.lives); else passed++;
        total++; if (io.level !== 3'd0) $display("FAIL replay level got=%0d want=0", io.level); else passed++;
        drive(1'b0, 1'b1, 1'b0);
        total++; if (io.lives !== 2'd2) $display("FAIL lose_c1 lives got=%0d want=2", io.lives); else passed++;
        wait_play("lose_c1");
        drive(1'b0, 1'b1, 1'b0);
        total++; if (io.lives !== 2'd1) $display("FAIL lose_c2 lives got=%0d want=1", io.lives); else passed++;
        wait_play("lose_c2");
        drive(1'b0, 1'b1, 1'b0);
        total++; if (io.state !== LOSE) $display("FAIL lose state got=%0d want=%0d", io.state, LOSE); else passed++;
        total++; if (io.lives !== 2'd0) $display("FAIL lose lives got=%0d want=0", io.lives); else passed++;
        total++; if (io.game_over !== 1'b1) $display("FAIL lose game_over got=%b want=1", io.game_over); else passed++;
        total++; if (io.flash !== 1'b0) $display("FAIL lose flash got=%b want=0", io.flash); else passed++;
        drive(1'b0, 1'b1, 1'b0);
        total++; if (io.lives !== 2'd0) $display("FAIL lose_sat lives got=%0d want=0", io.lives); else passed++;
        io.start_btn = 1'b1;
        step(1);
        total++; if (io.state !== IDLE) $display("FAIL held_start state got=%0d want=%0d", io.state, IDLE); else passed++;
        step(4);
        total++; if (io.state !== IDLE) $display("FAIL held_start_hold state got=%0d want=%0d", io.state, IDLE); else passed++;
        io.start_btn = 1'b0;
        step(1);
        total++; if (io.state !== IDLE) $display("FAIL held_start_release state got=%0d want=%0d", io.state, IDLE); else passed++;
    endtask

    task automatic test_same_cycle();
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        wait_play("same_pre");
        drive(1'b0, 1'b1, 1'b1);
        total++; if (io.state !== HIT) $display("FAIL same state got=%0d want=%0d", io.state, HIT); else passed++;
        total++; if (io.level !== 3'd1) $display("FAIL same level got=%0d want=1", io.level); else passed++;
        total++; if (io.lives !== 2'd2) $display("FAIL same lives got=%0d want=2", io.lives); else passed++;
    endtask

    task automatic test_reset_mid();
        step(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        count_idle_ticks("post_reset", 25, IDLE);
        drive(1'b1, 1'b0, 1'b0);
        total++; if (io.state !== PLAY) $display("FAIL post_reset_start state got=%0d want=%0d", io.state, PLAY); else passed++;
        exp_q.push_back(10);
        measure_tick("post_reset");
    endtask

    initial begin
        test_reset();
        test_start();
        test_hit();
        test_levels();
        test_lose();
        test_same_cycle();
        test_reset_mid();
        total++; if (exp_q.size() !== 0) $display("FAIL scoreboard leftover got=%0d want=0", exp_q.size()); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
